// File: rtl/clk_step_ctrl.sv
// Run/step/halt clock-enable sequencer for the single-cycle CPU: issues one-cycle tick_o pulses.
// Optional build macro DEBOUNCE_EN inserts a step-button debouncer after the synchroniser.
module clk_step_ctrl #(
  parameter int unsigned CTR_W       = 32,
  parameter int unsigned DIV_DEFAULT = 25_000_000,
  parameter int unsigned TCNT_W      = 16,
  parameter int unsigned DEB_CYCLES  = 500_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        mode_i,
  input  logic              step_i,
  input  logic              cpu_halt_i,
  input  logic              div_ld_i,
  input  logic [CTR_W-1:0]  div_val_i,
  output logic              tick_o,
  output logic [1:0]        state_o,
  output logic              halted_o,
  output logic [TCNT_W-1:0] tick_cnt_o
);

  localparam logic [1:0] S_HALT      = 2'b00;
  localparam logic [1:0] S_RUN       = 2'b01;
  localparam logic [1:0] S_STEP_ARM  = 2'b10;
  localparam logic [1:0] S_STEP_WAIT = 2'b11;

  localparam logic [1:0] M_HALT = 2'b00;
  localparam logic [1:0] M_RUN  = 2'b01;
  localparam logic [1:0] M_STEP = 2'b10;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CTR_W-1:0] ctr;
  logic [CTR_W-1:0] div_q;
  logic             sync_p0;
  logic             sync_p1;
  logic             step_lvl;
  logic             step_prev;
  logic             step_rise;
  logic             tick_nxt;

  // Stage p0/p1: two-flop synchroniser for the asynchronous button level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= step_i;
      sync_p1 <= sync_p0;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

  logic             deb_lvl;
  logic [DEB_W-1:0] deb_cnt;

  // Debounced level follows sync_p1 only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      deb_lvl <= 1'b0;
      deb_cnt <= '0;
    end else if (sync_p1 == deb_lvl) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
      deb_lvl <= sync_p1;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  assign step_lvl = deb_lvl;
`else
  logic unused_deb_cfg;

  assign unused_deb_cfg = (DEB_CYCLES == 0);
  assign step_lvl       = sync_p1;
`endif

  assign step_rise = step_lvl & ~step_prev;
  assign state_o   = state;

  always_comb begin
    state_nxt = state;
    tick_nxt  = 1'b0;
    if (halted_o) begin
      state_nxt = S_HALT;
    end else begin
      case (mode_i)
        M_RUN: begin
          state_nxt = S_RUN;
          // A load in the terminal cycle restarts the period instead of ticking
          tick_nxt  = (state == S_RUN) && (ctr == div_q) && !div_ld_i;
        end
        M_STEP: begin
          case (state)
            S_HALT, S_RUN: state_nxt = S_STEP_ARM;
            S_STEP_ARM: begin
              if (step_rise && !div_ld_i) begin
                tick_nxt  = 1'b1;
                state_nxt = S_STEP_WAIT;
              end
            end
            S_STEP_WAIT: begin
              if (!step_lvl) state_nxt = S_STEP_ARM;
            end
            default: state_nxt = S_HALT;
          endcase
        end
        default: state_nxt = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_HALT;
      ctr        <= '0;
      div_q      <= CTR_W'(DIV_DEFAULT);
      tick_o     <= 1'b0;
      halted_o   <= 1'b0;
      tick_cnt_o <= '0;
      step_prev  <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_o    <= tick_nxt;
      step_prev <= step_lvl;
      if (tick_nxt) tick_cnt_o <= tick_cnt_o + TCNT_W'(1);
      if (div_ld_i) begin
        div_q <= div_val_i;
        ctr   <= '0;
      end else if ((state != S_RUN) || (state_nxt != S_RUN) || (ctr == div_q)) begin
        ctr <= '0;
      end else begin
        ctr <= ctr + CTR_W'(1);
      end
      // The halt request rides on the tick being issued; it outranks a same-cycle clear
      if (tick_o && cpu_halt_i) begin
        halted_o <= 1'b1;
      end else if (mode_i == M_HALT) begin
        halted_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Self-checking bench for clk_step_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural reference model.
module tb_clk_step_ctrl;

  localparam int unsigned CTR_W       = 32;
  localparam int unsigned DIV_DEFAULT = 25_000_000;
  localparam int unsigned TCNT_W      = 16;
  localparam int unsigned DEB_CYCLES  = 500_000;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [1:0]        mode_i = 2'b00;
  logic              step_i = 1'b0;
  logic              cpu_halt_i = 1'b0;
  logic              div_ld_i = 1'b0;
  logic [CTR_W-1:0]  div_val_i = '0;
  logic              tick_o;
  logic [1:0]        state_o;
  logic              halted_o;
  logic [TCNT_W-1:0] tick_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int                m_state  = 0;
  bit                m_tick   = 1'b0;
  bit                m_halted = 1'b0;
  int unsigned       m_cnt    = 0;
  longint unsigned   m_div    = 0;
  longint unsigned   m_run    = 0;
  bit [2:0]          m_smp    = 3'b000;

  clk_step_ctrl #(
    .CTR_W      (CTR_W),
    .DIV_DEFAULT(DIV_DEFAULT),
    .TCNT_W     (TCNT_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .mode_i    (mode_i),
    .step_i    (step_i),
    .cpu_halt_i(cpu_halt_i),
    .div_ld_i  (div_ld_i),
    .div_val_i (div_val_i),
    .tick_o    (tick_o),
    .state_o   (state_o),
    .halted_o  (halted_o),
    .tick_cnt_o(tick_cnt_o)
  );

  always #10 clk_i = ~clk_i;

  // Advances the reference model by one clock edge from the inputs currently applied
  task automatic model_edge();
    bit lvl;
    bit rise;
    bit nt;
    bit nh;
    int ns;
    if (rst_i) begin
      m_state = 0; m_tick = 0; m_halted = 0; m_cnt = 0;
      m_div = DIV_DEFAULT; m_run = 0; m_smp = 3'b000;
      return;
    end
    lvl  = m_smp[1];
    rise = m_smp[1] && !m_smp[2];
    nt   = 0;
    if (m_halted) ns = 0;
    else if (mode_i == 2'b01) begin
      ns = 1;
      if (m_state == 1 && !div_ld_i && m_run == m_div) nt = 1;
    end else if (mode_i == 2'b10) begin
      if (m_state == 0 || m_state == 1) ns = 2;
      else if (m_state == 2) begin
        if (rise && !div_ld_i) begin nt = 1; ns = 3; end
        else ns = 2;
      end else ns = lvl ? 3 : 2;
    end else ns = 0;
    nh = m_halted;
    if (m_tick && cpu_halt_i) nh = 1;
    else if (mode_i == 2'b00) nh = 0;
    if (div_ld_i) begin
      m_div = div_val_i;
      m_run = 0;
    end else if (m_state == 1 && ns == 1 && !nt) m_run = m_run + 1;
    else m_run = 0;
    m_cnt    = (m_cnt + nt) % 65536;
    m_tick   = nt;
    m_state  = ns;
    m_halted = nh;
    m_smp    = {m_smp[1:0], step_i};
  endtask

  task automatic clk_cycle();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1; mode_i = 2'b00; step_i = 0; cpu_halt_i = 0; div_ld_i = 0; div_val_i = '0;
    clk_cycle();
    rst_i = 0;
  endtask

  task automatic load_and_run(input int unsigned val);
    div_ld_i = 1; div_val_i = val; mode_i = 2'b00;
    clk_cycle();
    div_ld_i = 0; mode_i = 2'b01;
    clk_cycle();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %0b expected 00", state_o); end
    n_checks++; if (tick_o !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %0b expected 0", tick_o); end
    n_checks++; if (halted_o !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b expected 0", halted_o); end
    n_checks++; if (tick_cnt_o !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt: got %0h expected 0", tick_cnt_o); end
  endtask

  task automatic test_run_div3();
    do_reset();
    load_and_run(3);
    n_checks++; if (state_o !== 2'b01) begin n_fail++; $display("FAIL run3_state: got %0b expected 01", state_o); end
    for (int k = 1; k <= 12; k++) begin
      clk_cycle();
      n_checks++;
      if (tick_o !== ((k % 4) == 0)) begin
        n_fail++; $display("FAIL run3_tick cycle %0d: got %0b expected %0b", k, tick_o, (k % 4) == 0);
      end
    end
    n_checks++; if (tick_cnt_o !== 16'd3) begin n_fail++; $display("FAIL run3_cnt: got %0d expected 3", tick_cnt_o); end
  endtask

  task automatic test_div0();
    do_reset();
    load_and_run(0);
    for (int k = 1; k <= 10; k++) begin
      clk_cycle();
      n_checks++; if (tick_o !== 1'b1) begin n_fail++; $display("FAIL div0_tick cycle %0d: got %0b expected 1", k, tick_o); end
    end
    n_checks++; if (tick_cnt_o !== 16'd10) begin n_fail++; $display("FAIL div0_cnt: got %0d expected 10", tick_cnt_o); end
    mode_i = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      clk_cycle();
      n_checks++; if (tick_o !== 1'b0) begin n_fail++; $display("FAIL div0_halt_tick cycle %0d: got %0b expected 0", k, tick_o); end
      n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL div0_halt_state cycle %0d: got %0b expected 00", k, state_o); end
    end
  endtask

  task automatic test_step();
    do_reset();
    mode_i = 2'b10;
    clk_cycle();
    n_checks++; if (state_o !== 2'b10) begin n_fail++; $display("FAIL step_arm: got %0b expected 10", state_o); end
    step_i = 1;
    for (int k = 1; k <= 20; k++) begin
      clk_cycle();
      n_checks++; if (tick_o !== (k == 3)) begin n_fail++; $display("FAIL step_hold_tick cycle %0d: got %0b expected %0b", k, tick_o, k == 3); end
      n_checks++; if (state_o !== ((k < 3) ? 2'b10 : 2'b11)) begin n_fail++; $display("FAIL step_hold_state cycle %0d: got %0b", k, state_o); end
    end
    step_i = 0;
    for (int k = 1; k <= 5; k++) begin
      clk_cycle();
      n_checks++; if (tick_o !== 1'b0) begin n_fail++; $display("FAIL step_rel_tick cycle %0d: got %0b expected 0", k, tick_o); end
      n_checks++; if (state_o !== ((k < 3) ? 2'b11 : 2'b10)) begin n_fail++; $display("FAIL step_rel_state cycle %0d: got %0b", k, state_o); end
    end
    step_i = 1;
    for (int k = 1; k <= 5; k++) begin
      clk_cycle();
      n_checks++; if (tick_o !== (k == 3)) begin n_fail++; $display("FAIL step_press2_tick cycle %0d: got %0b expected %0b", k, tick_o, k == 3); end
      n_checks++; if (state_o !== ((k < 3) ? 2'b10 : 2'b11)) begin n_fail++; $display("FAIL step_press2_state cycle %0d: got %0b", k, state_o); end
    end
    n_checks++; if (tick_cnt_o !== 16'd2) begin n_fail++; $display("FAIL step_cnt: got %0d expected 2", tick_cnt_o); end
    step_i = 0;
  endtask

  task automatic test_cpu_halt();
    do_reset();
    load_and_run(4);
    cpu_halt_i = 1;
    for (int k = 1; k <= 5; k++) begin
      clk_cycle();
      n_checks++; if (tick_o !== (k == 5)) begin n_fail++; $display("FAIL halt_tick cycle %0d: got %0b expected %0b", k, tick_o, k == 5); end
    end
    clk_cycle();
    cpu_halt_i = 0;
    n_checks++; if (halted_o !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %0b expected 1", halted_o); end
    n_checks++; if (tick_o !== 1'b0) begin n_fail++; $display("FAIL halt_no_tick: got %0b expected 0", tick_o); end
    clk_cycle();
    n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL halt_state: got %0b expected 00", state_o); end
    for (int k = 1; k <= 5; k++) begin
      clk_cycle();
      n_checks++; if (state_o !== 2'b00 || halted_o !== 1'b1 || tick_o !== 1'b0) begin
        n_fail++; $display("FAIL halt_sticky cycle %0d: state %0b halted %0b tick %0b expected 00 1 0", k, state_o, halted_o, tick_o);
      end
    end
    mode_i = 2'b00;
    clk_cycle();
    n_checks++; if (halted_o !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %0b expected 0", halted_o); end
    mode_i = 2'b01;
    clk_cycle();
    n_checks++; if (state_o !== 2'b01) begin n_fail++; $display("FAIL halt_resume_state: got %0b expected 01", state_o); end
    for (int k = 1; k <= 5; k++) begin
      clk_cycle();
      n_checks++; if (tick_o !== (k == 5)) begin n_fail++; $display("FAIL halt_resume_tick cycle %0d: got %0b expected %0b", k, tick_o, k == 5); end
    end
  endtask

  task automatic test_load_at_terminal();
    do_reset();
    load_and_run(4);
    for (int k = 1; k <= 4; k++) begin
      clk_cycle();
      n_checks++; if (tick_o !== 1'b0) begin n_fail++; $display("FAIL ldterm_pre cycle %0d: got %0b expected 0", k, tick_o); end
    end
    div_ld_i = 1; div_val_i = 9;
    clk_cycle();
    div_ld_i = 0;
    n_checks++; if (tick_o !== 1'b0) begin n_fail++; $display("FAIL ldterm_load_tick: got %0b expected 0", tick_o); end
    for (int k = 1; k <= 10; k++) begin
      clk_cycle();
      n_checks++; if (tick_o !== (k == 10)) begin n_fail++; $display("FAIL ldterm_next cycle %0d: got %0b expected %0b", k, tick_o, k == 10); end
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load_and_run(0);
    repeat (255) clk_cycle();
    n_checks++; if (tick_cnt_o !== 16'h00FF) begin n_fail++; $display("FAIL midrst_precnt: got %0h expected 00ff", tick_cnt_o); end
    rst_i = 1;
    clk_cycle();
    n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL midrst_state: got %0b expected 00", state_o); end
    n_checks++; if (tick_cnt_o !== 16'h0000) begin n_fail++; $display("FAIL midrst_cnt: got %0h expected 0", tick_cnt_o); end
    n_checks++; if (tick_o !== 1'b0) begin n_fail++; $display("FAIL midrst_tick: got %0b expected 0", tick_o); end
    rst_i = 0;
    for (int k = 1; k <= 40; k++) begin
      clk_cycle();
      n_checks++; if (tick_o !== 1'b0) begin n_fail++; $display("FAIL midrst_default_div cycle %0d: got %0b expected 0", k, tick_o); end
    end
  endtask

  task automatic test_random();
    int dur;
    do_reset();
    div_ld_i = 1; div_val_i = $urandom_range(0, 5);
    clk_cycle();
    div_ld_i = 0;
    for (int seg = 0; seg < 60; seg++) begin
      mode_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) mode_i = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      dur = $urandom_range(5, 50);
      for (int c = 0; c < dur; c++) begin
        if ($urandom_range(0, 5) == 0) step_i = ~step_i;
        cpu_halt_i = (mode_i != 2'b00) && ($urandom_range(0, 39) == 0);
        div_ld_i   = (mode_i != 2'b10) && ($urandom_range(0, 49) == 0);
        div_val_i  = $urandom_range(0, 7);
        clk_cycle();
        n_checks++;
        if (tick_o !== m_tick || state_o !== 2'(m_state) || halted_o !== m_halted || tick_cnt_o !== 16'(m_cnt)) begin
          n_fail++;
          $display("FAIL random seg %0d: got tick %0b state %0b halted %0b cnt %0d, expected %0b %0b %0b %0d",
                   seg, tick_o, state_o, halted_o, tick_cnt_o, m_tick, 2'(m_state), m_halted, m_cnt);
        end
      end
    end
    cpu_halt_i = 0; div_ld_i = 0; step_i = 0;
  endtask

  initial begin
    test_reset();
    test_run_div3();
    test_div0();
    test_step();
    test_cpu_halt();
    test_load_at_terminal();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
